// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller state encoding,
// forward S-box and GF(2^8) xtime over the 0x11b polynomial.
package aes_pkg;

  localparam int        NR_AES128 = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Row n of the FIPS-197 S-box occupies one 128-bit row; entry 0 is the MSB byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current
// key and the round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = key[127:96];
  assign w_w1 = key[95:64];
  assign w_w2 = key[63:32];
  assign w_w3 = key[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

  assign w_n0 = w_w0 ^ w_sub ^ {rcon, 24'h0};
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  assign next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/mixcolumns.sv
// Combinational AES MixColumns over a column-major 128-bit state.
module mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_state[127-32*c    -: 8];
    assign w_a1 = i_state[127-32*c-8  -: 8];
    assign w_a2 = i_state[127-32*c-16 -: 8];
    assign w_a3 = i_state[127-32*c-24 -: 8];
    // 3*a is xtime(a) ^ a.
    assign o_state[127-32*c    -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[127-32*c-8  -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[127-32*c-16 -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_state[127-32*c-24 -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: accepts a plaintext/key pair, runs
// one round per clock with on-the-fly key expansion, then presents ciphertext.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are
  // both high; valid/data from this block stay stable until that edge.

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes128_round_ctrl supports only NR == 10");
  end

  aes_fsm_e     r_fsm;
  logic [127:0] r_state_reg;
  logic [127:0] r_key_reg;
  logic [127:0] r_out_data;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round_idx;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_next_key;
  logic [127:0] w_round_out;
  logic         w_last_round;

  // SubBytes fused with ShiftRows: output (r,c) takes input (r,(c+r)%4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_sr[127-8*(r+4*c) -: 8] = sbox(r_state_reg[127-8*(r+4*((c+r)%4)) -: 8]);
    end
  end

  mixcolumns u_mixcolumns (
    .i_state (w_sr),
    .o_state (w_mc)
  );

  aes_key_step u_key_step (
    .key      (r_key_reg),
    .rcon     (r_rcon),
    .next_key (w_next_key)
  );

  assign w_last_round = (r_round_idx == 4'(NR));
  assign w_round_out  = (w_last_round ? w_sr : w_mc) ^ w_next_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_state_reg <= '0;
      r_key_reg   <= '0;
      r_out_data  <= '0;
      r_rcon      <= RCON_INIT;
      r_round_idx <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state_reg <= in_data ^ in_key;
            r_key_reg   <= in_key;
            r_rcon      <= RCON_INIT;
            r_round_idx <= 4'd1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_fsm       <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_key_reg   <= w_next_key;
          r_state_reg <= w_round_out;
          r_rcon      <= xtime(r_rcon);
          if (w_last_round) begin
            r_out_data  <= w_round_out;
            r_out_valid <= 1'b1;
            r_fsm       <= ST_DONE;
          end else begin
            r_round_idx <= r_round_idx + 4'd1;
          end
        end
        ST_DONE: begin
          // in_ready stays low here, so no block is accepted on the same edge.
          if (out_ready) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_round_idx <= '0;
            r_fsm       <= ST_IDLE;
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_out_data  <= '0;
          r_round_idx <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign round_idx = r_round_idx;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 known-answer vectors,
// backpressure, input-change immunity, mid-run reset and back-to-back blocks.
module tb_aes128_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK1_C = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];

  aes128_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy"},      128'(busy),      128'd0);
    chk({tag, "_out_data"},  out_data,        128'd0);
  endtask

  // Wait (bounded) for out_valid; returns ticks waited.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_timeout observed=no out_valid expected=out_valid", tag);
    end
  endtask

  initial begin
    int n;
    int acc_cyc[2];
    int n_acc;
    int n_out;
    logic [127:0] hold_data;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_key = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_idle("reset");
    chk("reset_round_idx", 128'(round_idx), 128'd0);
    chk("reset_rcon", 128'(dut.r_rcon), 128'h01);

    // FIPS-197 App. B with out_ready high, latency 10
    in_valid = 1'b1; in_data = PT_B; in_key = KEY_B; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b_accept_busy", 128'(busy), 128'd1);
    chk("b_accept_in_ready", 128'(in_ready), 128'd0);
    chk("b_accept_round_idx", 128'(round_idx), 128'd1);
    chk("b_run_out_data", out_data, 128'd0);
    wait_out("b", n);
    chk("b_latency", 128'(n), 128'd10);
    chk("b_ct", out_data, CT_B);
    chk("b_done_round_idx", 128'(round_idx), 128'd10);
    tick();
    check_idle("b_after");
    chk("b_after_round_idx", 128'(round_idx), 128'd0);

    // FIPS-197 App. C.1 with round tracking and backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = PT_C; in_key = KEY_C;
    tick();
    in_valid = 1'b0;
    chk("c_round_idx_1", 128'(round_idx), 128'd1);
    for (int k = 1; k <= 9; k++) begin
      out_ready = 1'b1;  // ignored while running
      tick();
      if (k == 1) chk("c_round1_key", dut.r_key_reg, RK1_C);
      chk($sformatf("c_round_idx_%0d", k + 1), 128'(round_idx), 128'(k + 1));
      chk("c_run_out_valid", 128'(out_valid), 128'd0);
    end
    out_ready = 1'b0;
    tick();
    chk("c_out_valid", 128'(out_valid), 128'd1);
    chk("c_ct", out_data, CT_C);
    in_valid = 1'b1; in_data = PT_B; in_key = KEY_B;  // ignored in DONE
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, CT_C);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_idle("bp_release");
    tick();
    chk("bp_no_start", 128'(busy), 128'd0);

    // Input-change immunity during RUN
    in_valid = 1'b1; in_data = PT_B; in_key = KEY_B;
    tick();
    for (int k = 1; k <= 9; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("imm_round_idx", 128'(round_idx), 128'(k + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("imm_out_valid", 128'(out_valid), 128'd1);
    chk("imm_ct", out_data, CT_B);
    tick();
    check_idle("imm_after");

    // Mid-operation reset at round 5, then a clean App. B block
    in_valid = 1'b1; in_data = PT_C; in_key = KEY_C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mr_round_idx_5", 128'(round_idx), 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mr");
    chk("mr_round_idx", 128'(round_idx), 128'd0);
    in_valid = 1'b1; in_data = PT_B; in_key = KEY_B;
    tick();
    in_valid = 1'b0;
    wait_out("mr_b", n);
    chk("mr_latency", 128'(n), 128'd10);
    chk("mr_ct", out_data, CT_B);
    tick();

    // Back-to-back with in_valid held and out_ready high
    exp_q.push_back(CT_B);
    exp_q.push_back(CT_C);
    in_valid = 1'b1; in_data = PT_B; in_key = KEY_B; out_ready = 1'b1;
    n_acc = 0;
    n_out = 0;
    for (int k = 0; k < 40 && n_out < 2; k++) begin
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid) begin
        hold_data = exp_q.pop_front();
        chk("b2b_ct", out_data, hold_data);
        n_out++;
      end
      tick();
      if (n_acc == 1) begin in_data = PT_C; in_key = KEY_C; end
      if (n_acc == 2) in_valid = 1'b0;
    end
    chk("b2b_outputs", 128'(n_out), 128'd2);
    chk("b2b_accepts", 128'(n_acc), 128'd2);
    if (n_acc == 2) chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    tick();
    check_idle("b2b_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
